// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: exception priority, CSR/GPR commit, flush/redirect, retire count, trace
//
// Holds one instruction from the memory stage and commits it combinationally
// during the cycle it sits in WB; GPR/CSR state updates land at the next edge.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   ms_to_ws_valid / ws_allowin   handshake with the memory stage (WB never stalls)
//   ms_*                          instruction payload from the memory stage
//   has_int, csr_rd_value,
//   csr_eentry_pc, csr_eertn_pc   inputs from the CSR file
//   csr_*                         exception / ERTN / read / write ports to the CSR file
//   ws_flush, ws_flush_pc         pipeline flush pulse and redirect target
//   rf_*                          GPR write port
//   ws_fwd_*                      forwarding tag for earlier stages
//   retire_cnt                    committed non-excepting instruction count
//   debug_wb_*                    commit trace
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic             ms_gr_we,
    input  logic [4:0]       ms_dest,
    input  logic [31:0]      ms_result,
    input  logic [4:0]       ms_exc,
    input  logic             ms_ertn,
    input  logic             ms_csr_re,
    input  logic             ms_csr_we,
    input  logic [13:0]      ms_csr_num,
    input  logic [31:0]      ms_csr_wmask,
    input  logic [31:0]      ms_csr_wvalue,
    input  logic             has_int,
    input  logic [31:0]      csr_rd_value,
    input  logic [31:0]      csr_eentry_pc,
    input  logic [31:0]      csr_eertn_pc,
    output logic [5:0]       csr_exc,
    output logic             csr_ertn_flush,
    output logic             csr_re,
    output logic [13:0]      csr_rd_num,
    output logic             csr_we,
    output logic [13:0]      csr_wr_num,
    output logic [31:0]      csr_wr_mask,
    output logic [31:0]      csr_wr_value,
    output logic [31:0]      csr_wb_pc,
    output logic             ws_flush,
    output logic [31:0]      ws_flush_pc,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             ws_fwd_valid,
    output logic [4:0]       ws_fwd_dest,
    output logic [31:0]      ws_fwd_data,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    // ms_exc / exc_q bit positions: {ADEF,ALE,BRK,INE,SYS}
    localparam int E_ADEF = 4;
    localparam int E_ALE  = 3;
    localparam int E_BRK  = 2;
    localparam int E_INE  = 1;
    localparam int E_SYS  = 0;
    // csr_exc adds INT on top: {INT,ADEF,ALE,BRK,INE,SYS}
    localparam int X_INT  = 5;

    logic             ws_valid_q,   ws_valid_d;
    logic [31:0]      pc_q,         pc_d;
    logic             gr_we_q,      gr_we_d;
    logic [4:0]       dest_q,       dest_d;
    logic [31:0]      result_q,     result_d;
    logic [4:0]       exc_q,        exc_d;
    logic             ertn_q,       ertn_d;
    logic             csr_re_q,     csr_re_d;
    logic             csr_we_q,     csr_we_d;
    logic [13:0]      csr_num_q,    csr_num_d;
    logic [31:0]      csr_wmask_q,  csr_wmask_d;
    logic [31:0]      csr_wvalue_q, csr_wvalue_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic             accept;
    logic             int_take;
    logic             ex_any;
    logic             commit;
    logic [5:0]       exc_win;

    // Fixed-priority pick: INT > ADEF > INE > SYS > BRK > ALE. An interrupt
    // overrides whatever the instruction raised on its own.
    always_comb begin
        exc_win  = 6'd0;
        int_take = ws_valid_q & has_int;
        if (ws_valid_q) begin
            if (int_take)            exc_win[X_INT]  = 1'b1;
            else if (exc_q[E_ADEF])  exc_win[E_ADEF] = 1'b1;
            else if (exc_q[E_INE])   exc_win[E_INE]  = 1'b1;
            else if (exc_q[E_SYS])   exc_win[E_SYS]  = 1'b1;
            else if (exc_q[E_BRK])   exc_win[E_BRK]  = 1'b1;
            else if (exc_q[E_ALE])   exc_win[E_ALE]  = 1'b1;
        end
    end

    assign ex_any         = ws_valid_q & (|exc_win);
    assign commit         = ws_valid_q & ~ex_any;

    assign ws_allowin     = resetn;
    assign csr_exc        = exc_win;
    assign csr_ertn_flush = ws_valid_q & ertn_q & ~ex_any;
    assign ws_flush       = ex_any | csr_ertn_flush;
    assign ws_flush_pc    = !ws_valid_q ? 32'd0 : (ex_any ? csr_eentry_pc : csr_eertn_pc);

    // Data outputs are forced to zero while WB is empty so stale payload never leaks.
    assign csr_re         = ws_valid_q & csr_re_q & ~ex_any;
    assign csr_we         = ws_valid_q & csr_we_q & ~ex_any;
    assign csr_rd_num     = ws_valid_q ? csr_num_q    : 14'd0;
    assign csr_wr_num     = ws_valid_q ? csr_num_q    : 14'd0;
    assign csr_wr_mask    = ws_valid_q ? csr_wmask_q  : 32'd0;
    assign csr_wr_value   = ws_valid_q ? csr_wvalue_q : 32'd0;
    assign csr_wb_pc      = ws_valid_q ? pc_q         : 32'd0;

    // CSR read data is the pre-write value: the CSR file updates at the edge.
    assign rf_we          = ws_valid_q & gr_we_q & ~ex_any & (dest_q != 5'd0);
    assign rf_waddr       = ws_valid_q ? dest_q : 5'd0;
    assign rf_wdata       = !ws_valid_q ? 32'd0 : (csr_re_q ? csr_rd_value : result_q);

    assign ws_fwd_valid   = rf_we;
    assign ws_fwd_dest    = rf_waddr;
    assign ws_fwd_data    = rf_wdata;

    assign retire_cnt     = retire_cnt_q;

    assign debug_wb_pc       = ws_valid_q ? pc_q : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // A flush from the instruction now in WB kills whatever arrives this cycle.
    always_comb begin
        accept       = ms_to_ws_valid & ws_allowin & ~ws_flush;
        ws_valid_d   = accept;
        pc_d         = pc_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        result_d     = result_q;
        exc_d        = exc_q;
        ertn_d       = ertn_q;
        csr_re_d     = csr_re_q;
        csr_we_d     = csr_we_q;
        csr_num_d    = csr_num_q;
        csr_wmask_d  = csr_wmask_q;
        csr_wvalue_d = csr_wvalue_q;
        if (accept) begin
            pc_d         = ms_pc;
            gr_we_d      = ms_gr_we;
            dest_d       = ms_dest;
            result_d     = ms_result;
            exc_d        = ms_exc;
            ertn_d       = ms_ertn;
            csr_re_d     = ms_csr_re;
            csr_we_d     = ms_csr_we;
            csr_num_d    = ms_csr_num;
            csr_wmask_d  = ms_csr_wmask;
            csr_wvalue_d = ms_csr_wvalue;
        end
        retire_cnt_d = retire_cnt_q + CNT_W'(commit);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q   <= 1'b0;
            pc_q         <= 32'd0;
            gr_we_q      <= 1'b0;
            dest_q       <= 5'd0;
            result_q     <= 32'd0;
            exc_q        <= 5'd0;
            ertn_q       <= 1'b0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= 14'd0;
            csr_wmask_q  <= 32'd0;
            csr_wvalue_q <= 32'd0;
            retire_cnt_q <= '0;
        end else begin
            ws_valid_q   <= ws_valid_d;
            pc_q         <= pc_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            result_q     <= result_d;
            exc_q        <= exc_d;
            ertn_q       <= ertn_d;
            csr_re_q     <= csr_re_d;
            csr_we_q     <= csr_we_d;
            csr_num_q    <= csr_num_d;
            csr_wmask_q  <= csr_wmask_d;
            csr_wvalue_q <= csr_wvalue_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with a spec-level reference model
module tb_wb_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [4:0]  exc;
        logic        ertn;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
    } inst_t;

    typedef struct packed {
        logic        allowin;
        logic [5:0]  exc;
        logic        ertn;
        logic        re;
        logic        we;
        logic [13:0] num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [31:0] wb_pc;
        logic        flush;
        logic [31:0] flush_pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  retire;
        logic [31:0] dbg_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ms_to_ws_valid = 1'b0;
    logic        ws_allowin;
    logic [31:0] ms_pc = '0;
    logic        ms_gr_we = 1'b0;
    logic [4:0]  ms_dest = '0;
    logic [31:0] ms_result = '0;
    logic [4:0]  ms_exc = '0;
    logic        ms_ertn = 1'b0;
    logic        ms_csr_re = 1'b0;
    logic        ms_csr_we = 1'b0;
    logic [13:0] ms_csr_num = '0;
    logic [31:0] ms_csr_wmask = '0;
    logic [31:0] ms_csr_wvalue = '0;
    logic        has_int = 1'b0;
    logic [31:0] csr_rd_value = '0;
    logic [31:0] csr_eentry_pc = '0;
    logic [31:0] csr_eertn_pc = '0;
    logic [5:0]  csr_exc;
    logic        csr_ertn_flush;
    logic        csr_re;
    logic [13:0] csr_rd_num;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic [31:0] csr_wb_pc;
    logic        ws_flush;
    logic [31:0] ws_flush_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [3:0]  retire_cnt;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage #(.CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_exc(ms_exc), .ms_ertn(ms_ertn), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .has_int(has_int), .csr_rd_value(csr_rd_value),
        .csr_eentry_pc(csr_eentry_pc), .csr_eertn_pc(csr_eertn_pc),
        .csr_exc(csr_exc), .csr_ertn_flush(csr_ertn_flush),
        .csr_re(csr_re), .csr_rd_num(csr_rd_num), .csr_we(csr_we), .csr_wr_num(csr_wr_num),
        .csr_wr_mask(csr_wr_mask), .csr_wr_value(csr_wr_value), .csr_wb_pc(csr_wb_pc),
        .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
        .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    exp_t  sb[$];

    // Reference model state: the instruction currently in WB and the retire count.
    inst_t wb_m  = '0;
    inst_t pend  = '0;
    exp_t  cur_e = '0;
    logic [3:0] cnt_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs for one cycle, straight from the commit rules.
    function automatic exp_t model_out(input inst_t w, input logic hi, input logic [31:0] rdv,
                                       input logic [31:0] ee, input logic [31:0] er,
                                       input logic [3:0] cnt);
        exp_t e;
        logic [5:0] raw;
        logic found;
        int order[6] = '{5, 4, 1, 0, 2, 3};   // INT ADEF INE SYS BRK ALE
        e = '0;
        e.allowin = 1'b1;
        e.retire  = cnt;
        if (w.valid) begin
            raw   = {hi, w.exc};
            found = 1'b0;
            foreach (order[k]) begin
                if (!found && raw[order[k]]) begin
                    e.exc[order[k]] = 1'b1;
                    found = 1'b1;
                end
            end
            e.ertn     = w.ertn && !found;
            e.flush    = found || e.ertn;
            e.flush_pc = found ? ee : er;
            e.re       = w.csr_re && !found;
            e.we       = w.csr_we && !found;
            e.num      = w.csr_num;
            e.wmask    = w.wmask;
            e.wvalue   = w.wvalue;
            e.wb_pc    = w.pc;
            e.dbg_pc   = w.pc;
            e.rf_we    = w.gr_we && !found && (w.dest != 5'd0);
            e.waddr    = w.dest;
            e.wdata    = w.csr_re ? rdv : w.result;
        end
        return e;
    endfunction

    // Called at posedge+1: drive next instruction and CSR-side inputs, queue expectation.
    task automatic drive(input inst_t nxt, input logic hi, input logic [31:0] rdv,
                         input logic [31:0] ee, input logic [31:0] er);
        ms_to_ws_valid = nxt.valid;
        ms_pc          = nxt.pc;
        ms_gr_we       = nxt.gr_we;
        ms_dest        = nxt.dest;
        ms_result      = nxt.result;
        ms_exc         = nxt.exc;
        ms_ertn        = nxt.ertn;
        ms_csr_re      = nxt.csr_re;
        ms_csr_we      = nxt.csr_we;
        ms_csr_num     = nxt.csr_num;
        ms_csr_wmask   = nxt.wmask;
        ms_csr_wvalue  = nxt.wvalue;
        has_int        = hi;
        csr_rd_value   = rdv;
        csr_eentry_pc  = ee;
        csr_eertn_pc   = er;
        cur_e = model_out(wb_m, hi, rdv, ee, er, cnt_m);
        pend  = nxt;
        sb.push_back(cur_e);
    endtask

    task automatic advance();
        if (wb_m.valid && cur_e.exc == 6'd0) cnt_m = cnt_m + 4'd1;
        wb_m = (pend.valid && !cur_e.flush) ? pend : inst_t'('0);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input inst_t nxt, input logic hi, input logic [31:0] rdv,
                        input logic [31:0] ee, input logic [31:0] er);
        drive(nxt, hi, rdv, ee, er);
        advance();
    endtask

    function automatic inst_t alu(input logic [31:0] pc, input logic [4:0] dest,
                                  input logic [31:0] res);
        inst_t i = '0;
        i.valid = 1'b1; i.pc = pc; i.gr_we = 1'b1; i.dest = dest; i.result = res;
        return i;
    endfunction

    function automatic inst_t rnd_inst();
        inst_t i;
        i.valid  = ($urandom_range(3) != 0);
        i.pc     = $urandom & 32'hffff_fffc;
        i.gr_we  = ($urandom_range(3) != 0);
        i.dest   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        i.result = $urandom;
        i.exc    = ($urandom_range(4) == 0) ? 5'($urandom) : 5'd0;
        i.ertn   = ($urandom_range(7) == 0);
        i.csr_re = ($urandom_range(3) == 0);
        i.csr_we = ($urandom_range(3) == 0);
        i.csr_num = 14'($urandom);
        i.wmask  = $urandom;
        i.wvalue = $urandom;
        return i;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 64'({csr_exc, csr_ertn_flush, csr_re, csr_we, ws_flush,
                                  rf_we, ws_fwd_valid, debug_wb_rf_we}), 64'd0);
        chk({tag, "_allowin"}, 64'(ws_allowin), 64'(resetn));
        chk({tag, "_retire"},  64'(retire_cnt), 64'd0);
        chk({tag, "_csrdata"}, {csr_rd_num, csr_wr_num, 4'd0, csr_wb_pc}, 64'd0);
        chk({tag, "_csrwr"},   {csr_wr_mask, csr_wr_value}, 64'd0);
        chk({tag, "_flushpc"}, 64'(ws_flush_pc), 64'd0);
        chk({tag, "_rf"},      {rf_waddr, ws_fwd_dest, debug_wb_rf_wnum, 17'd0, rf_wdata}, 64'd0);
        chk({tag, "_fwdtrace"}, {ws_fwd_data, debug_wb_rf_wdata}, 64'd0);
        chk({tag, "_dbgpc"},   64'(debug_wb_pc), 64'd0);
    endtask

    // Monitor: compares DUT outputs against the queued expectation every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("allowin",   64'(ws_allowin),     64'(e.allowin));
                chk("csr_exc",   64'(csr_exc),        64'(e.exc));
                chk("ertn_fl",   64'(csr_ertn_flush), 64'(e.ertn));
                chk("csr_re",    64'(csr_re),         64'(e.re));
                chk("csr_we",    64'(csr_we),         64'(e.we));
                chk("csr_nums",  64'({csr_rd_num, csr_wr_num}), 64'({e.num, e.num}));
                chk("csr_wr",    {csr_wr_mask, csr_wr_value}, {e.wmask, e.wvalue});
                chk("csr_wb_pc", 64'(csr_wb_pc),      64'(e.wb_pc));
                chk("ws_flush",  64'(ws_flush),       64'(e.flush));
                chk("flush_pc",  64'(ws_flush_pc),    64'(e.flush_pc));
                chk("rf_we",     64'(rf_we),          64'(e.rf_we));
                chk("rf_waddr",  64'(rf_waddr),       64'(e.waddr));
                chk("rf_wdata",  64'(rf_wdata),       64'(e.wdata));
                chk("fwd",       {ws_fwd_valid, 26'd0, ws_fwd_dest, ws_fwd_data},
                                 {e.rf_we, 26'd0, e.waddr, e.wdata});
                chk("retire",    64'(retire_cnt),     64'(e.retire));
                chk("trace",     {debug_wb_rf_we, debug_wb_rf_wnum, 23'd0, debug_wb_pc},
                                 {{4{e.rf_we}}, e.waddr, 23'd0, e.dbg_pc});
                chk("trace_d",   64'(debug_wb_rf_wdata), 64'(e.wdata));
            end
        end
    end

    initial begin
        inst_t i;
        inst_t nop = '0;
        localparam logic [31:0] EE = 32'h1c00_8000;
        localparam logic [31:0] ER = 32'h1c00_0204;

        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        chk("allowin_after_reset", 64'(ws_allowin), 64'd1);
        @(posedge clk); #1;

        // ADD commits, retire 0->1
        step(alu(32'h1c00_0100, 5'd4, 32'h1234_5678), 1'b0, 32'd0, EE, ER);
        // SYSCALL, with an instruction arriving while it flushes
        i = '0; i.valid = 1'b1; i.pc = 32'h1c00_0200; i.exc = 5'b00001;
        step(i, 1'b0, 32'd0, EE, ER);
        step(alu(32'h1c00_0204, 5'd5, 32'h0000_0055), 1'b0, 32'd0, EE, ER);
        // ERTN, then ERTN carrying INE
        i = '0; i.valid = 1'b1; i.pc = 32'h1c00_8010; i.ertn = 1'b1;
        step(i, 1'b0, 32'd0, EE, ER);
        i.exc = 5'b00010;
        step(i, 1'b0, 32'd0, EE, ER);
        // CSRWR SAVE0 hit by an interrupt in WB
        i = '0; i.valid = 1'b1; i.pc = 32'h1c00_0300; i.csr_we = 1'b1;
        i.csr_num = 14'h30; i.wmask = 32'hffff_ffff; i.wvalue = 32'hdead_beef;
        step(i, 1'b0, 32'd0, EE, ER);
        // ADEF+SYS together
        i = '0; i.valid = 1'b1; i.pc = 32'h1c00_0400; i.exc = 5'b10001;
        step(i, 1'b1, 32'd0, EE, ER);
        // CSRRD ESTAT to r7, then to r0
        i = '0; i.valid = 1'b1; i.pc = 32'h1c00_0500; i.gr_we = 1'b1; i.dest = 5'd7;
        i.csr_re = 1'b1; i.csr_num = 14'h5;
        step(i, 1'b0, 32'd0, EE, ER);
        i.dest = 5'd0;
        step(i, 1'b0, 32'h0000_0800, EE, ER);
        step(nop, 1'b0, 32'h0000_0800, EE, ER);
        step(nop, 1'b0, 32'd0, EE, ER);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(rnd_inst(), ($urandom_range(9) == 0), $urandom, $urandom, $urandom);
        end

        // Three-instruction stream, reset dropped while the second is in WB
        step(alu(32'h1c00_0600, 5'd1, 32'h11), 1'b0, 32'd0, EE, ER);
        step(alu(32'h1c00_0604, 5'd2, 32'h22), 1'b0, 32'd0, EE, ER);
        drive(alu(32'h1c00_0608, 5'd3, 32'h33), 1'b0, 32'd0, EE, ER);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        wb_m = '0; cnt_m = '0; sb.delete();
        ms_to_ws_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset_hold");
        resetn = 1'b1;
        #1;
        chk("allowin_after_midreset", 64'(ws_allowin), 64'd1);

        // 16 retires on a 4-bit counter: 15 -> 0 wrap
        for (int n = 0; n < 16; n++) begin
            step(alu(32'h1c00_0700 + 32'(n * 4), 5'd9, 32'(n)), 1'b0, 32'd0, EE, ER);
        end
        step(nop, 1'b0, 32'd0, EE, ER);
        chk("retire_wrap", 64'(retire_cnt), 64'd0);
        step(nop, 1'b0, 32'd0, EE, ER);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
